dmni_mem_arbiter: RTL and testbench

//  Shares the single DMNI memory port between the DMA send channel (reads packet

---
 rtl/dmni_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmni_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dmni_mem_arbiter.sv
// Round-robin arbiter sharing the DMNI memory port between the DMA send (read)
// and receive (write) channels, with a bounded burst length per grant.
module dmni_mem_arbiter #(
    parameter int unsigned BURST_LEN = 8,
    parameter bit          RCV_FIRST = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        snd_req_i,
    input  logic [31:0] snd_addr_i,
    output logic        snd_gnt_o,
    output logic        snd_rvalid_o,
    output logic [31:0] snd_rdata_o,
    input  logic        rcv_req_i,
    input  logic [3:0]  rcv_we_i,
    input  logic [31:0] rcv_addr_i,
    input  logic [31:0] rcv_data_i,
    output logic        rcv_gnt_o,
    output logic        mem_en_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i
);

    localparam int unsigned      CNT_W    = (BURST_LEN > 8) ? $clog2(BURST_LEN) : 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SND  = 2'd1,
        ST_RCV  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_last_rcv;
    logic             w_last_rcv_nxt;
    logic             r_snd_rvalid;
    logic             w_snd_gnt;
    logic             w_rcv_gnt;

    assign w_snd_gnt = (r_state == ST_SND) & snd_req_i;
    assign w_rcv_gnt = (r_state == ST_RCV) & rcv_req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_rcv   <= ~RCV_FIRST;
            r_snd_rvalid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_rcv   <= w_last_rcv_nxt;
            r_snd_rvalid <= w_snd_gnt;
        end
    end

    // A burst-expiry hand-over passes through IDLE with last_owner updated, so
    // IDLE picks the waiting channel next cycle; that is the one-cycle switch gap.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_last_rcv_nxt = r_last_rcv;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (snd_req_i && rcv_req_i) begin
                    w_state_nxt = r_last_rcv ? ST_SND : ST_RCV;
                end else if (snd_req_i) begin
                    w_state_nxt = ST_SND;
                end else if (rcv_req_i) begin
                    w_state_nxt = ST_RCV;
                end
            end
            ST_SND: begin
                if (!snd_req_i) begin
                    w_cnt_nxt      = '0;
                    w_last_rcv_nxt = 1'b0;
                    w_state_nxt    = rcv_req_i ? ST_RCV : ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (rcv_req_i) begin
                        w_last_rcv_nxt = 1'b0;
                        w_state_nxt    = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RCV: begin
                if (!rcv_req_i) begin
                    w_cnt_nxt      = '0;
                    w_last_rcv_nxt = 1'b1;
                    w_state_nxt    = snd_req_i ? ST_SND : ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (snd_req_i) begin
                        w_last_rcv_nxt = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign snd_gnt_o    = w_snd_gnt;
    assign rcv_gnt_o    = w_rcv_gnt;
    assign snd_rvalid_o = r_snd_rvalid;
    assign snd_rdata_o  = mem_data_i;

    assign mem_en_o   = w_snd_gnt | w_rcv_gnt;
    assign mem_we_o   = w_rcv_gnt ? rcv_we_i : 4'b0000;
    assign mem_addr_o = (r_state == ST_SND) ? snd_addr_i : rcv_addr_i;
    assign mem_data_o = rcv_data_i;

endmodule

// File: tb/tb_dmni_mem_arbiter.sv
// Directed bench for dmni_mem_arbiter: BURST_LEN=8 instance with a byte-write
// memory model, plus a BURST_LEN=1 instance for strict alternation.
module tb_dmni_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // BURST_LEN=8 instance
    logic        a_snd_req, a_snd_gnt, a_snd_rvalid, a_rcv_req, a_rcv_gnt, a_mem_en;
    logic [31:0] a_snd_addr, a_snd_rdata, a_rcv_addr, a_rcv_data, a_mem_addr, a_mem_wdata;
    logic [31:0] a_mem_rdata;
    logic [3:0]  a_rcv_we, a_mem_we;

    // BURST_LEN=1 instance
    logic        b_snd_req, b_snd_gnt, b_snd_rvalid, b_rcv_req, b_rcv_gnt, b_mem_en;
    logic [31:0] b_snd_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_we;

    dmni_mem_arbiter #(.BURST_LEN(8), .RCV_FIRST(1'b1)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n),
        .snd_req_i(a_snd_req), .snd_addr_i(a_snd_addr), .snd_gnt_o(a_snd_gnt),
        .snd_rvalid_o(a_snd_rvalid), .snd_rdata_o(a_snd_rdata),
        .rcv_req_i(a_rcv_req), .rcv_we_i(a_rcv_we), .rcv_addr_i(a_rcv_addr),
        .rcv_data_i(a_rcv_data), .rcv_gnt_o(a_rcv_gnt),
        .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
        .mem_data_o(a_mem_wdata), .mem_data_i(a_mem_rdata)
    );

    dmni_mem_arbiter #(.BURST_LEN(1), .RCV_FIRST(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .snd_req_i(b_snd_req), .snd_addr_i(32'h0), .snd_gnt_o(b_snd_gnt),
        .snd_rvalid_o(b_snd_rvalid), .snd_rdata_o(b_snd_rdata),
        .rcv_req_i(b_rcv_req), .rcv_we_i(4'h0), .rcv_addr_i(32'h0),
        .rcv_data_i(32'h0), .rcv_gnt_o(b_rcv_gnt),
        .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_data_o(b_mem_wdata), .mem_data_i(32'h0)
    );

    // Word memory, one-cycle read latency; unwritten words read back their own address.
    logic [31:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 32'(i) << 2;

    always @(posedge clk) begin
        if (a_mem_en) begin
            if (|a_mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (a_mem_we[b]) mem[a_mem_addr[9:2]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
            end else begin
                a_mem_rdata <= mem[a_mem_addr[9:2]];
            end
        end
    end

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        a_snd_req  = 1'b0; a_snd_addr = '0;
        a_rcv_req  = 1'b0; a_rcv_we = '0; a_rcv_addr = '0; a_rcv_data = '0;
        b_snd_req  = 1'b0; b_rcv_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // reset state with requests already pending
        do_reset();
        rst_n = 1'b0;
        a_snd_req = 1'b1; a_rcv_req = 1'b1; a_rcv_we = 4'hF;
        tick();
        #2;
        chk("rst_snd_gnt", 32'(a_snd_gnt), 32'd0);
        chk("rst_rcv_gnt", 32'(a_rcv_gnt), 32'd0);
        chk("rst_mem_en",  32'(a_mem_en), 32'd0);
        chk("rst_mem_we",  32'(a_mem_we), 32'd0);
        chk("rst_rvalid",  32'(a_snd_rvalid), 32'd0);

        // 1: reset pulse on beat 3 of an 8-beat snd burst
        do_reset();
        a_snd_req = 1'b1; a_snd_addr = 32'h300;
        #2 chk("t1_idle_gnt", 32'(a_snd_gnt), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #2 chk("t1_beat_gnt", 32'(a_snd_gnt), 32'd1);
            if (i < 2) tick();
        end
        rst_n = 1'b0;
        #1;
        chk("t1_rst_gnt", 32'(a_snd_gnt), 32'd0);
        chk("t1_rst_en",  32'(a_mem_en), 32'd0);
        tick();
        chk("t1_no_rvalid", 32'(a_snd_rvalid), 32'd0);
        rst_n = 1'b1;
        #2 chk("t1_post_idle", 32'(a_snd_gnt), 32'd0);
        tick();
        #2 chk("t1_post_gnt", 32'(a_snd_gnt), 32'd1);

        // 2: contention from reset, rcv first, 8-beat bursts with one-cycle gap
        do_reset();
        a_snd_req = 1'b1; a_rcv_req = 1'b1; a_rcv_we = 4'h0;
        for (int c = 1; c <= 20; c++) begin
            #2;
            chk($sformatf("t2_rcv_c%0d", c), 32'(a_rcv_gnt), 32'((c >= 2 && c <= 9) || c == 20));
            chk($sformatf("t2_snd_c%0d", c), 32'(a_snd_gnt), 32'(c >= 11 && c <= 18));
            tick();
        end

        // 3: snd alone, 20 back-to-back beats, rdata = address
        do_reset();
        a_snd_req = 1'b1; a_snd_addr = 32'h200;
        #2 chk("t3_first_gnt", 32'(a_snd_gnt), 32'd0);
        chk("t3_first_rv", 32'(a_snd_rvalid), 32'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            a_snd_addr = 32'h200 + 32'(4 * i);
            #2;
            chk($sformatf("t3_gnt%0d", i), 32'(a_snd_gnt), 32'd1);
            chk($sformatf("t3_addr%0d", i), a_mem_addr, 32'h200 + 32'(4 * i));
            if (i > 0) begin
                chk($sformatf("t3_rv%0d", i), 32'(a_snd_rvalid), 32'd1);
                chk($sformatf("t3_rd%0d", i), a_snd_rdata, 32'h200 + 32'(4 * (i - 1)));
            end
            tick();
        end
        a_snd_req = 1'b0;
        #2;
        chk("t3_last_rv", 32'(a_snd_rvalid), 32'd1);
        chk("t3_last_rd", a_snd_rdata, 32'h24C);
        chk("t3_we0", 32'(a_mem_we), 32'd0);
        tick();
        chk("t3_rv_off", 32'(a_snd_rvalid), 32'd0);

        // 4: partial write then read-back of the same word
        do_reset();
        a_rcv_req = 1'b1; a_rcv_addr = 32'h100; a_rcv_data = 32'hCAFEBABE; a_rcv_we = 4'b0011;
        #2 chk("t4_idle", 32'(a_rcv_gnt), 32'd0);
        tick();
        #2;
        chk("t4_wgnt", 32'(a_rcv_gnt), 32'd1);
        chk("t4_wen",  32'(a_mem_en), 32'd1);
        chk("t4_we",   32'(a_mem_we), 32'h3);
        chk("t4_waddr", a_mem_addr, 32'h100);
        chk("t4_wdata", a_mem_wdata, 32'hCAFEBABE);
        tick();
        a_rcv_req = 1'b0; a_rcv_we = 4'h0; a_snd_req = 1'b1; a_snd_addr = 32'h100;
        #2 chk("t4_switch", 32'(a_snd_gnt | a_rcv_gnt), 32'd0);
        tick();
        #2;
        chk("t4_rgnt", 32'(a_snd_gnt), 32'd1);
        chk("t4_rwe",  32'(a_mem_we), 32'd0);
        chk("t4_raddr", a_mem_addr, 32'h100);
        tick();
        a_snd_req = 1'b0;
        #2;
        chk("t4_rv", 32'(a_snd_rvalid), 32'd1);
        chk("t4_rdata", a_snd_rdata, 32'h0000BABE);

        // 5: BURST_LEN=1, continuous contention alternates with gaps
        do_reset();
        b_snd_req = 1'b1; b_rcv_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            #2;
            chk($sformatf("t5_rcv_c%0d", c), 32'(b_rcv_gnt), 32'(c % 4 == 2));
            chk($sformatf("t5_snd_c%0d", c), 32'(b_snd_gnt), 32'(c % 4 == 0));
            chk($sformatf("t5_en_c%0d", c), 32'(b_mem_en), 32'(c % 2 == 0));
            tick();
        end
        b_snd_req = 1'b0; b_rcv_req = 1'b0;

        // 6: owner drops mid-burst; re-request restarts a full 8-beat burst
        do_reset();
        a_snd_req = 1'b1; a_snd_addr = 32'h40;
        for (int c = 1; c <= 15; c++) begin
            a_snd_req = (c != 4);
            a_rcv_req = (c >= 6);
            #2;
            chk($sformatf("t6_snd_c%0d", c), 32'(a_snd_gnt),
                32'(c == 2 || c == 3 || (c >= 6 && c <= 13)));
            chk($sformatf("t6_rcv_c%0d", c), 32'(a_rcv_gnt), 32'(c == 15));
            if (c == 15) chk("t6_noop_we", 32'(a_mem_we), 32'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
